seven_seg_scanner: RTL and testbench
====================================

# seven_seg_scanner

Parametrised, time-multiplexed driver for a bank of `p_ndigits` common-anode seven-segment digits. Decodes full hexadecimal (0–F) per digit, with per-digit blanking, decimal points and optional leading-zero suppression. Includes inter-digit dead time against ghosting, and a valid/ready load port whose updates commit only at frame boundaries, so a frame never tears. Sits between the processor's memory-mapped display register and the FPGA pins, replacing single-digit combinational decoding.

## Interface
Parameters:
- `p_ndigits`, default 4: number of digits, legal 1–8.
- `p_dwell`, default 50000: cycles each digit is lit per scan, legal ≥1.
- `p_dead`, default 500: all-off cycles before each digit is lit, legal ≥0; 0 removes the DEAD state.

Ports:
- `clk`, input, 1: the single clock; all state updates on its rising edge.
- `rst`, input, 1: reset, synchronous and active-high.
- `in_val`, input, 1: load request.
- `in_rdy`, output, 1: pending slot empty; a load is accepted when `in_val & in_rdy`.
- `in_data`, input, 4*p_ndigits: nibble i drives digit i; digit 0 is rightmost.
- `in_blank`, input, p_ndigits: 1 forces digit i fully off.
- `in_dp`, input, p_ndigits: 1 lights the decimal point of digit i.
- `lz_en`, input, 1: leading-zero suppression enable; sampled live, not latched.
- `seg`, output, 7: active-low segments; `seg[0]`=a … `seg[6]`=g.
- `dp_n`, output, 1: active-low decimal point.
- `an`, output, p_ndigits: active-low digit select; at most one bit is low.

## Operation
- Registers:
  - display set `disp_{data,blank,dp}`.
  - pending set `pend_{data,blank,dp}` plus `pend_v`.
  - scan FSM: state DEAD/ON, digit index `idx` (0..p_ndigits-1), dwell counter `cnt`.
- Reset: `idx`=0, state=DEAD (ON if `p_dead`=0), `cnt`=0, `disp_blank`=all 1s, `pend_v`=0. Registered outputs take these values in the cycle after `rst` is sampled high: `an`=all 1s, `seg`=7'b1111111, `dp_n`=1, `in_rdy`=1.
- `in_rdy` = ~`pend_v`, registered. On accept, the pending set is written and `pend_v`←1.
- Holding `in_val` while `in_rdy`=0: no effect. The producer holds its data until it is accepted.
- FSM transitions:
  - DEAD: count `p_dead` cycles, then go to ON with `cnt`=0.
  - ON: count `p_dwell` cycles, then go to DEAD and `idx`←(`idx`+1) mod `p_ndigits`.
- Frame boundary: the last ON cycle of `idx`=p_ndigits-1.
  - If `pend_v`=1, the display set ← pending set and `pend_v`←0.
  - An accept in that same cycle writes pending and sets `pend_v`=1; it commits at the next boundary.
- Leading-zero suppression: digit i is suppressed when `lz_en`=1, i>0, and `disp_data` nibbles i..p_ndigits-1 are all 0. Digit 0 is never suppressed by this rule.
- Digit visible = ~`disp_blank[i]` & ~suppressed.
  - Visible digit: `seg`=hex decode of nibble i.
  - Invisible digit: `seg`=7'b1111111.
  - `dp_n` = ~`disp_dp[i]` regardless of blanking.
- DEAD: `an`, `seg` and `dp_n` all 1s. ON: `an`=~(1<<`idx`).
- Hex decode, active-low, listed as `seg[6:0]`:
  - 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000
  - 8=0000000, 9=0010000, A=0001000, b=0000011, C=1000110, d=0100001, E=0000110, F=0001110

## Timing
- All outputs are registered. Outputs reflect FSM state with 1-cycle latency.
- Scan period per digit = `p_dead`+`p_dwell` cycles. Frame = `p_ndigits`·(`p_dead`+`p_dwell`).
- Accept to visible on the pins: from the next frame boundary +1 cycle; worst case one frame + 1.
- `in_rdy` falls the cycle after an accept and rises the cycle after a commit.
- `rst` asserted mid-frame: the pending set is discarded and outputs return to reset values on the next cycle.
- Counter widths are $clog2(max(p_dwell,p_dead,2)). The index wraps without an overflow cycle.

## Structure
- Package `seven_seg_pkg`:
  - the 16 hex segment constants.
  - `SEG_OFF`=7'b1111111.
  - FSM state enum {DEAD, ON}.
- Sub-module `seven_seg_hex_decode`: combinational, 4-bit in → 7-bit active-low out. Instantiated once, on the nibble muxed by `idx`.

## Test plan
All scenarios use `p_ndigits`=4, `p_dwell`=4, `p_dead`=1, giving a 20-cycle frame.
- Reset, then idle: `an`=1111, `seg`=1111111 for every digit, `in_rdy`=1 the cycle after reset.
- Load 0x12AF, blank=0, dp=0010: after the boundary, `an`=1110 shows F (0001110), 1101 shows A with `dp_n`=0, 1011 shows 2, 0111 shows 1; each is low for 4 cycles and separated by 1 all-off cycle.
- Second load during the frame: `in_rdy`=0 until the boundary; a third `in_val` pulse while `in_rdy`=0 is ignored, and only the second data appears.
- Load exactly on a boundary cycle: not shown during the next frame, shown from the following frame.
- Load 0x0050 with `lz_en`=1: digits 3 and 2 off, digit 1 shows 5, digit 0 shows 0. Drop `lz_en` to 0 mid-frame: 0 appears on digits 3 and 2 at their next scan.
- Assert `rst` mid-frame with a load pending: the next cycle shows reset outputs and `in_rdy`=1; the pending data is never displayed.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// Shared constants and types for the seven-segment scanner:
// active-low hex glyphs (seg[6:0] = g..a), the all-off pattern, scan states.
package seven_seg_pkg;

  localparam logic [6:0] HEX_0 = 7'b1000000;
  localparam logic [6:0] HEX_1 = 7'b1111001;
  localparam logic [6:0] HEX_2 = 7'b0100100;
  localparam logic [6:0] HEX_3 = 7'b0110000;
  localparam logic [6:0] HEX_4 = 7'b0011001;
  localparam logic [6:0] HEX_5 = 7'b0010010;
  localparam logic [6:0] HEX_6 = 7'b0000010;
  localparam logic [6:0] HEX_7 = 7'b1111000;
  localparam logic [6:0] HEX_8 = 7'b0000000;
  localparam logic [6:0] HEX_9 = 7'b0010000;
  localparam logic [6:0] HEX_A = 7'b0001000;
  localparam logic [6:0] HEX_B = 7'b0000011;
  localparam logic [6:0] HEX_C = 7'b1000110;
  localparam logic [6:0] HEX_D = 7'b0100001;
  localparam logic [6:0] HEX_E = 7'b0000110;
  localparam logic [6:0] HEX_F = 7'b0001110;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  // DEAD: all digits off between scans; ON: one digit lit
  typedef enum logic {
    DEAD = 1'b0,
    ON   = 1'b1
  } state_t;

endpackage

// File: rtl/seven_seg_scanner_if.sv
// Load port of the scanner: a full display image offered with valid/ready.
//
// Handshake: the producer raises in_val with in_data/in_blank/in_dp and holds
// all of them stable until a rising clk edge where in_val & in_rdy are both 1;
// that edge is the transfer. in_rdy never depends combinationally on in_val.
interface seven_seg_scanner_if #(
  parameter int p_ndigits = 4
);
  logic                     in_val;
  logic                     in_rdy;
  logic [4*p_ndigits-1:0]   in_data;
  logic [p_ndigits-1:0]     in_blank;
  logic [p_ndigits-1:0]     in_dp;

  modport master (output in_val, output in_data, output in_blank, output in_dp,
                  input  in_rdy);
  modport slave  (input  in_val, input  in_data, input  in_blank, input  in_dp,
                  output in_rdy);
endinterface

// File: rtl/seven_seg_hex_decode.sv
// Combinational hex nibble to active-low seven-segment glyph.
module seven_seg_hex_decode
  import seven_seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);

  // Glyph lookup
  always_comb begin
    seg = SEG_OFF;
    case (nib)
      4'h0: seg = HEX_0;
      4'h1: seg = HEX_1;
      4'h2: seg = HEX_2;
      4'h3: seg = HEX_3;
      4'h4: seg = HEX_4;
      4'h5: seg = HEX_5;
      4'h6: seg = HEX_6;
      4'h7: seg = HEX_7;
      4'h8: seg = HEX_8;
      4'h9: seg = HEX_9;
      4'hA: seg = HEX_A;
      4'hB: seg = HEX_B;
      4'hC: seg = HEX_C;
      4'hD: seg = HEX_D;
      4'hE: seg = HEX_E;
      4'hF: seg = HEX_F;
      default: seg = SEG_OFF;
    endcase
  end

endmodule

// File: rtl/seven_seg_scanner.sv
// Time-multiplexed common-anode seven-segment driver. A DEAD/ON scan walks
// the digits; a pending image loaded over the valid/ready port is promoted to
// the display image only at the end of a frame, so a frame never tears.
module seven_seg_scanner
  import seven_seg_pkg::*;
#(
  parameter int p_ndigits = 4,
  parameter int p_dwell   = 50000,
  parameter int p_dead    = 500
) (
  input  logic                 clk,
  input  logic                 rst,
  seven_seg_scanner_if.slave   ld,
  input  logic                 lz_en,
  output logic [6:0]           seg,
  output logic                 dp_n,
  output logic [p_ndigits-1:0] an,
  output state_t               dbg_state
);

  localparam int CMAX = (p_dwell > p_dead) ? ((p_dwell > 2) ? p_dwell : 2)
                                           : ((p_dead  > 2) ? p_dead  : 2);
  localparam int CW   = $clog2(CMAX);
  localparam int IW   = (p_ndigits > 1) ? $clog2(p_ndigits) : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(p_dwell - 1);
  localparam logic [CW-1:0] DEAD_LAST  = CW'((p_dead > 0) ? p_dead - 1 : 0);
  localparam logic [IW-1:0] LAST_IDX   = IW'(p_ndigits - 1);
  localparam state_t        INIT_STATE = (p_dead == 0) ? ON : DEAD;

  state_t                 state;
  logic [IW-1:0]          idx;
  logic [CW-1:0]          cnt;

  logic [4*p_ndigits-1:0] disp_data, pend_data;
  logic [p_ndigits-1:0]   disp_blank, pend_blank;
  logic [p_ndigits-1:0]   disp_dp, pend_dp;
  logic                   pend_v;

  logic [3:0]             nib;
  logic                   cur_blank, cur_dp, cur_sup;
  logic [p_ndigits:0]     zero_from;
  logic [p_ndigits-1:0]   an_on;
  logic [6:0]             dec_seg;
  logic                   boundary, accept, pend_v_next;

  assign dbg_state = state;

  // Select the current digit's nibble/flags and decide leading-zero suppression
  always_comb begin
    nib       = 4'h0;
    cur_blank = 1'b1;
    cur_dp    = 1'b0;
    cur_sup   = 1'b0;
    an_on     = '1;
    zero_from = '0;
    zero_from[p_ndigits] = 1'b1;
    for (int i = p_ndigits - 1; i >= 0; i--) begin
      zero_from[i] = zero_from[i+1] & (disp_data[4*i +: 4] == 4'h0);
    end
    for (int i = 0; i < p_ndigits; i++) begin
      if (idx == IW'(i)) begin
        nib       = disp_data[4*i +: 4];
        cur_blank = disp_blank[i];
        cur_dp    = disp_dp[i];
        cur_sup   = lz_en & (i != 0) & zero_from[i];
        an_on[i]  = 1'b0;
      end
    end
  end

  seven_seg_hex_decode u_dec (
    .nib (nib),
    .seg (dec_seg)
  );

  assign boundary    = (state == ON) && (cnt == DWELL_LAST) && (idx == LAST_IDX);
  assign accept      = ld.in_val & ld.in_rdy;
  assign pend_v_next = accept | (pend_v & ~boundary);

  // Scan FSM with registered pin outputs (pins show the state one cycle late)
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= INIT_STATE;
      idx   <= '0;
      cnt   <= '0;
      an    <= '1;
      seg   <= SEG_OFF;
      dp_n  <= 1'b1;
    end else begin
      case (state)
        DEAD: begin
          an   <= '1;
          seg  <= SEG_OFF;
          dp_n <= 1'b1;
          if (cnt == DEAD_LAST) begin
            state <= ON;
            cnt   <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ON: begin
          an   <= an_on;
          seg  <= (~cur_blank & ~cur_sup) ? dec_seg : SEG_OFF;
          dp_n <= ~cur_dp;
          if (cnt == DWELL_LAST) begin
            cnt   <= '0;
            idx   <= (idx == LAST_IDX) ? '0 : idx + 1'b1;
            state <= (p_dead == 0) ? ON : DEAD;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
      endcase
    end
  end

  // Pending slot and frame-boundary commit into the display image
  always_ff @(posedge clk) begin
    if (rst) begin
      pend_v     <= 1'b0;
      ld.in_rdy  <= 1'b1;
      disp_data  <= '0;
      disp_blank <= '1;
      disp_dp    <= '0;
    end else begin
      if (boundary && pend_v) begin
        disp_data  <= pend_data;
        disp_blank <= pend_blank;
        disp_dp    <= pend_dp;
      end
      if (accept) begin
        pend_data  <= ld.in_data;
        pend_blank <= ld.in_blank;
        pend_dp    <= ld.in_dp;
      end
      pend_v    <= pend_v_next;
      ld.in_rdy <= ~pend_v_next;
    end
  end

endmodule

// File: tb/tb_seven_seg_scanner.sv
// Bench for seven_seg_scanner (4 digits, dwell 4, dead 1, 20-cycle frame).
// A cycle-level reference model derives the pins from elapsed time since
// reset and the frame-level load/commit rules; directed steps add fixed-glyph
// checks for the documented scenarios, then random loads run against the model.
module tb_seven_seg_scanner;
  import seven_seg_pkg::*;

  localparam int ND    = 4;
  localparam int DWELL = 4;
  localparam int DEADC = 1;
  localparam int SLOT  = DWELL + DEADC;
  localparam int FRAME = ND * SLOT;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          lz_en = 1'b0;
  logic [6:0]    seg;
  logic          dp_n;
  logic [ND-1:0] an;
  state_t        dbg_state;

  seven_seg_scanner_if #(.p_ndigits(ND)) ld ();

  seven_seg_scanner #(.p_ndigits(ND), .p_dwell(DWELL), .p_dead(DEADC)) dut (
    .clk       (clk),
    .rst       (rst),
    .ld        (ld),
    .lz_en     (lz_en),
    .seg       (seg),
    .dp_n      (dp_n),
    .an        (an),
    .dbg_state (dbg_state)
  );

  // Clock
  always #5 clk = ~clk;

  logic [6:0] hex_tab [16] = '{7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
                               7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
                               7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
                               7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110};

  int n_cmp  = 0;
  int n_fail = 0;

  // Reference model state
  int            m_t;
  logic [15:0]   m_data, p_data;
  logic [ND-1:0] m_blank, p_blank, m_dp, p_dp;
  logic          m_pend_v, m_acc;
  logic [ND-1:0] e_an;
  logic [6:0]    e_seg;
  logic          e_dp, e_rdy;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  // Model step at a rising edge: pins after this edge, then commit/accept
  task automatic model_edge();
    int pos, d, ph;
    logic [3:0] nv;
    logic vis;
    if (rst) begin
      m_t = 0; m_pend_v = 1'b0; m_acc = 1'b0;
      m_data = '0; m_blank = '1; m_dp = '0;
      e_an = '1; e_seg = 7'h7f; e_dp = 1'b1; e_rdy = 1'b1;
    end else begin
      pos = m_t % FRAME;
      d   = pos / SLOT;
      ph  = pos % SLOT;
      if (ph < DEADC) begin
        e_an = '1; e_seg = 7'h7f; e_dp = 1'b1;
      end else begin
        nv   = 4'((m_data >> (4 * d)) & 16'hF);
        vis  = !m_blank[d] && !(lz_en && d > 0 && (m_data >> (4 * d)) == 0);
        e_an = ~(ND'(1) << d);
        e_seg = vis ? hex_tab[nv] : 7'h7f;
        e_dp = !m_dp[d];
      end
      if (pos == FRAME - 1 && m_pend_v) begin
        m_data = p_data; m_blank = p_blank; m_dp = p_dp;
        m_pend_v = 1'b0;
      end
      m_acc = ld.in_val && e_rdy;
      if (m_acc) begin
        p_data = ld.in_data; p_blank = ld.in_blank; p_dp = ld.in_dp;
        m_pend_v = 1'b1;
      end
      e_rdy = !m_pend_v;
      m_t++;
    end
  endtask

  task automatic tick();
    @(posedge clk);
    model_edge();
    #1;
    check("an",     8'(an),   8'(e_an));
    check("seg",    8'(seg),  8'(e_seg));
    check("dp_n",   8'(dp_n), 8'(e_dp));
    check("in_rdy", 8'(ld.in_rdy), 8'(e_rdy));
  endtask

  task automatic load(input logic [15:0] data, input logic [ND-1:0] blank,
                      input logic [ND-1:0] dp);
    ld.in_data = data; ld.in_blank = blank; ld.in_dp = dp; ld.in_val = 1'b1;
    for (int k = 0; k < 100; k++) begin
      tick();
      if (m_acc) break;
    end
    ld.in_val = 1'b0;
    check("rdy_fall_after_accept", 8'(ld.in_rdy), 8'd0);
  endtask

  task automatic wait_commit();
    for (int k = 0; k < 3 * FRAME && m_pend_v; k++) tick();
    check("rdy_after_commit", 8'(ld.in_rdy), 8'd1);
  endtask

  task automatic expect_shown(input string tag, input logic [ND-1:0] an_pat,
                              input logic [6:0] seg_pat, input logic dp_pat);
    logic found = 1'b0;
    for (int k = 0; k < 2 * FRAME && !found; k++) begin
      tick();
      if (an === an_pat) found = 1'b1;
    end
    check({tag, "_seen"}, 8'(found), 8'd1);
    check({tag, "_seg"},  8'(seg),   8'(seg_pat));
    check({tag, "_dp"},   8'(dp_n),  8'(dp_pat));
  endtask

  initial begin
    logic [15:0] rd;
    ld.in_val = 1'b0; ld.in_data = '0; ld.in_blank = '0; ld.in_dp = '0;

    // Reset, then idle scan of a blank display
    tick(); tick();
    check("reset_an",    8'(an),        8'h0f);
    check("reset_seg",   8'(seg),       8'h7f);
    check("reset_dp",    8'(dp_n),      8'd1);
    check("reset_rdy",   8'(ld.in_rdy), 8'd1);
    check("reset_state", 8'(dbg_state), 8'(DEAD));
    rst = 1'b0;
    for (int k = 0; k < 25; k++) tick();

    // 0x12AF with the decimal point on digit 1
    load(16'h12AF, 4'b0000, 4'b0010);
    wait_commit();
    expect_shown("d0_F", 4'b1110, 7'b0001110, 1'b1);
    expect_shown("d1_A", 4'b1101, 7'b0001000, 1'b0);
    expect_shown("d2_2", 4'b1011, 7'b0100100, 1'b1);
    expect_shown("d3_1", 4'b0111, 7'b1111001, 1'b1);

    // Second load mid-frame; a third pulse while not ready is ignored
    load(16'h3456, 4'b0000, 4'b0000);
    ld.in_data = 16'h9999; ld.in_val = 1'b1;
    tick();
    ld.in_val = 1'b0;
    check("third_pulse_rdy", 8'(ld.in_rdy), 8'd0);
    wait_commit();
    expect_shown("l2_d0", 4'b1110, 7'b0000010, 1'b1);
    expect_shown("l2_d1", 4'b1101, 7'b0010010, 1'b1);
    expect_shown("l2_d2", 4'b1011, 7'b0011001, 1'b1);
    expect_shown("l2_d3", 4'b0111, 7'b0110000, 1'b1);

    // Load landing exactly on the boundary cycle
    for (int k = 0; k < 2 * FRAME && (m_t % FRAME) != FRAME - 1; k++) tick();
    ld.in_data = 16'hC0DE; ld.in_blank = '0; ld.in_dp = '0; ld.in_val = 1'b1;
    tick();
    ld.in_val = 1'b0;
    expect_shown("bnd_old", 4'b1110, 7'b0000010, 1'b1);
    wait_commit();
    expect_shown("bnd_new", 4'b1110, 7'b0000110, 1'b1);

    // Leading-zero suppression, then dropped live
    lz_en = 1'b1;
    load(16'h0050, 4'b0000, 4'b0000);
    wait_commit();
    expect_shown("lz_d0", 4'b1110, 7'b1000000, 1'b1);
    expect_shown("lz_d1", 4'b1101, 7'b0010010, 1'b1);
    expect_shown("lz_d2", 4'b1011, 7'b1111111, 1'b1);
    expect_shown("lz_d3", 4'b0111, 7'b1111111, 1'b1);
    lz_en = 1'b0;
    expect_shown("nolz_d2", 4'b1011, 7'b1000000, 1'b1);
    expect_shown("nolz_d3", 4'b0111, 7'b1000000, 1'b1);

    // Random loads, blanking, dp and lz against the model
    for (int n = 0; n < 25; n++) begin
      rd = ($urandom_range(0, 1) == 1) ? 16'($urandom_range(0, 255)) : 16'($urandom);
      lz_en = 1'($urandom_range(0, 1));
      load(rd, 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
      for (int k = 0; k < int'($urandom_range(0, 30)); k++) tick();
    end
    wait_commit();

    // Reset mid-frame with a load pending
    lz_en = 1'b0;
    for (int k = 0; k < 7; k++) tick();
    load(16'h8888, 4'b0000, 4'b1111);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("midrst_an",  8'(an),        8'h0f);
    check("midrst_seg", 8'(seg),       8'h7f);
    check("midrst_rdy", 8'(ld.in_rdy), 8'd1);
    for (int k = 0; k < 2 * FRAME + 5; k++) tick();
    check("midrst_blank_seg", 8'(seg), 8'h7f);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
